// File: rtl/tf_addr_gen.sv
// rtl/tf_addr_gen.sv - twiddle exponent generator for radix-2 DIF FFT; `TFAG_INV_EN adds INV/CONJ for IFFT
module tf_addr_gen #(
  parameter int LOG2N = 5,
  parameter int EXPW  = 4
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  input  logic            HOLD,
`ifdef TFAG_INV_EN
  input  logic            INV,
  output logic            CONJ,
`endif
  output logic [EXPW-1:0] EXP0,
  output logic [EXPW-1:0] EXP1,
  output logic [2:0]      STAGE,
  output logic [EXPW-2:0] BF_PAIR,
  output logic            VALID,
  output logic            VALID_TF,
  output logic            BUSY,
  output logic            DONE
);

  localparam int         KW     = EXPW - 1;
  localparam logic [2:0] LAST_S = 3'(LOG2N - 1);

  // RUN issues pairs; LAST shows the final pair until it is released by HOLD=0;
  // DRAIN is the cycle carrying the final VALID_TF; DONE follows on IDLE entry.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DRAIN} state_t;

  state_t          state;
  logic [2:0]      cnt_s;
  logic [KW-1:0]   cnt_k;
  logic            issue;
  logic            last_pair;
  logic [EXPW-1:0] j0;
  logic [EXPW-1:0] j1;
  logic [EXPW-1:0] mask;
  logic [EXPW-1:0] nxt_e0;
  logic [EXPW-1:0] nxt_e1;
`ifdef TFAG_INV_EN
  logic            inv_lat;
`endif

  // exp(s,j) = (j mod (N/2 >> s)) << s; the modulo is a mask of the low (EXPW-s) bits
  always_comb begin
    j0        = {cnt_k, 1'b0};
    j1        = {cnt_k, 1'b1};
    mask      = {EXPW{1'b1}} >> cnt_s;
    nxt_e0    = (j0 & mask) << cnt_s;
    nxt_e1    = (j1 & mask) << cnt_s;
    last_pair = (cnt_s == LAST_S) && (cnt_k == {KW{1'b1}});
    issue     = !HOLD && ((state == S_IDLE && START) || state == S_RUN);
  end

  // frame FSM, pair counters and registered outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      cnt_s    <= 3'd0;
      cnt_k    <= '0;
      EXP0     <= '0;
      EXP1     <= '0;
      STAGE    <= 3'd0;
      BF_PAIR  <= '0;
      VALID    <= 1'b0;
      VALID_TF <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
`ifdef TFAG_INV_EN
      inv_lat  <= 1'b0;
      CONJ     <= 1'b0;
`endif
    end else begin
      DONE     <= 1'b0;
      // a held pair keeps its ROM address, so its TF is flagged once HOLD drops
      VALID_TF <= VALID & ~HOLD;
`ifdef TFAG_INV_EN
      CONJ     <= VALID & ~HOLD & inv_lat;
`endif
      if (issue) begin
        EXP0    <= nxt_e0;
        EXP1    <= nxt_e1;
        STAGE   <= cnt_s;
        BF_PAIR <= cnt_k;
        VALID   <= 1'b1;
        if (last_pair) begin
          cnt_s <= 3'd0;
          cnt_k <= '0;
        end else begin
          cnt_k <= cnt_k + 1'b1;
          if (cnt_k == {KW{1'b1}}) cnt_s <= cnt_s + 3'd1;
        end
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            state <= S_RUN;
            BUSY  <= 1'b1;
`ifdef TFAG_INV_EN
            inv_lat <= INV;
`endif
          end
        end
        S_RUN: begin
          if (issue && last_pair) state <= S_LAST;
        end
        S_LAST: begin
          if (!HOLD) begin
            state <= S_DRAIN;
            VALID <= 1'b0;
          end
        end
        S_DRAIN: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
